viterbi_decoder_k3: RTL
=======================

Name: viterbi_decoder_k3

Overview:
- Hard-decision Viterbi decoder for the team's rate-1/2, K=3 convolutional code. Sits directly downstream of the convolutional encoder, after the channel.
- Consumes one 2-bit parity symbol per handshake and runs add-compare-select over a 4-state trellis.
- Frames are zero-tail terminated. At end of frame the decoder traces back from state 0 and streams the decoded information bits out in original order.

Parameters:
- FRAME_LEN, 16, information bits per frame; the frame is FRAME_LEN+2 symbols including 2 tail zeros.
- PM_W, 8, path-metric width in bits; metrics saturate at 2^PM_W-1.

Ports:
- CLK  input  1  clock; all logic on posedge.
- RST  input  1  synchronous, active-high reset.
- in_valid  input  1  parities holds a valid symbol.
- in_ready  output  1  decoder accepts a symbol this cycle.
- parities  input  2  received symbol; [0]=p0, [1]=p1.
- out_valid  output  1  out_bit is valid.
- out_ready  input  1  downstream accepts out_bit.
- out_bit  output  1  decoded information bit.
- out_last  output  1  marks the final bit of the frame.
- out_metric  output  PM_W  final state-0 path metric; valid with out_last.

Behaviour:
- Code definition. Input u_t; state S={S[1]=u_(t-1), S[0]=u_(t-2)}; start state 00.
  - p0 = u_t ^ S[1]
  - p1 = u_t ^ S[1] ^ S[0]
  - next state = {u_t, S[1]}
- Reset (RST=1 at posedge): state=ACS, symbol counter=0, PM[0]=0, PM[1..3]=2^(PM_W-1). Outputs: in_ready=1, out_valid=0, out_bit=0, out_last=0, out_metric=0.
- RST mid-frame in any state aborts the frame and discards all partial data. No output follows for that frame.
- FSM states: ACS, TRACEBACK, OUTPUT.
- ACS:
  - in_ready=1. A symbol is accepted when in_valid && in_ready; updated metrics are visible the next cycle. One symbol per cycle maximum.
  - Branch metric = Hamming distance between parities and the expected {p1,p0}; range 0..2.
  - Next state n={u,a} has predecessors {a,0} and {a,1}. Candidate = PM[pred] + BM, with saturating add.
  - Pick the smaller candidate. On a tie, pick the predecessor with LSB 0.
  - Survivor bit SV[t][n] = LSB of the chosen predecessor; storage is (FRAME_LEN+2)x4 bits.
  - After accepting symbol FRAME_LEN+1 (counter wrap), latch PM[0] into out_metric and go to TRACEBACK.
  - in_valid while in_ready=0 is ignored; the upstream must hold the symbol.
- TRACEBACK:
  - in_ready=0. Runs exactly FRAME_LEN+2 cycles, one step per cycle, from t=FRAME_LEN+1 down to 0, starting at cur=00.
  - Each step: u_t = cur[1]; cur <= {cur[0], SV[t][cur]}.
  - Bits with t<FRAME_LEN are written to the output buffer at index t. Tail bits are discarded.
  - Then go to OUTPUT with read index 0.
- OUTPUT:
  - out_valid=1 and out_bit=buf[idx]; out_last=1 when idx=FRAME_LEN-1.
  - idx advances on out_valid && out_ready. out_bit, out_last and out_valid stay stable while out_ready=0.
  - After the last handshake: out_valid=0, then reinitialise metrics as at reset, counter=0, go to ACS. in_ready=1 the next cycle.
- Latency: last input symbol accepted at cycle C → first out_valid at cycle C+FRAME_LEN+3. This assumes out_ready held high.
- Errors are never signalled. With zero-tail termination, any single channel bit error in a frame decodes correctly (dfree=4). out_metric equals the number of corrected bit errors when decoding succeeds.

Test Plan:
- Clean frame, FRAME_LEN=4, u=1,0,1,1: symbols {p1,p0}=11,11,01,00,01,10 → out_bit 1,0,1,1; out_last on the 4th bit; out_metric=0.
- Same frame with symbol 2 corrupted 01→11 → out_bit 1,0,1,1; out_metric=1.
- Backpressure and gapped input: in_valid toggled 1/0, out_ready low for 3 cycles mid-output → same bits; no bit dropped or duplicated; out_bit held stable while stalled.
- Default FRAME_LEN=16, all-zero frame (18 symbols of 00) → 16 zero bits, out_metric=0. Immediately followed by an all-ones-info frame → 16 ones, out_metric=0.
- RST asserted after 7 symbols of a frame, then a clean full frame → out_valid stays 0 until the new frame completes; output matches the new frame only.
- Latency check: clean frame with out_ready=1 → first out_valid exactly FRAME_LEN+3 cycles after the last input handshake; in_ready=0 from then until the final output handshake.

Source files
------------

// File: rtl/viterbi_decoder_k3.sv
// Hard-decision Viterbi decoder for the rate-1/2, K=3 convolutional code
// (p0 = u ^ s1, p1 = u ^ s1 ^ s0). Four-state add-compare-select with
// saturating metrics, zero-tail frames, traceback from state 0, and
// in-order streaming of the decoded information bits.
module viterbi_decoder_k3 #(
    parameter int FRAME_LEN = 16,
    parameter int PM_W      = 8
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      parities,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_bit,
    output logic            out_last,
    output logic [PM_W-1:0] out_metric
);

    localparam int NSYM  = FRAME_LEN + 2;
    localparam int CNT_W = $clog2(NSYM);
    localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [PM_W-1:0] PM_INIT = {1'b1, {(PM_W-1){1'b0}}};

    typedef enum logic [1:0] {ACS, TRACEBACK, OUTPUT} state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [CNT_W-1:0]      tb_t_q, tb_t_d;
    logic [1:0]            cur_q, cur_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [PM_W-1:0]       pm_q [4];
    logic [PM_W-1:0]       pm_d [4];
    logic [PM_W-1:0]       metric_q, metric_d;
    logic [3:0]            sv_q [NSYM];
    logic [3:0]            sv_d [NSYM];
    logic [FRAME_LEN-1:0]  buf_q, buf_d;

    logic [PM_W-1:0]       pm_acs [4];
    logic [3:0]            sv_acs;

    function automatic logic [PM_W-1:0] sat_add(input logic [PM_W-1:0] a,
                                                 input logic [1:0] b);
        logic [PM_W:0] s;
        s = {1'b0, a} + {{(PM_W-1){1'b0}}, b};
        return s[PM_W] ? '1 : s[PM_W-1:0];
    endfunction

    // Hamming distance between the received symbol and the branch output
    // of leaving state s with input u.
    function automatic logic [1:0] bm(input logic [1:0] rx,
                                      input logic [1:0] s,
                                      input logic u);
        logic [1:0] d;
        d = rx ^ {u ^ s[1] ^ s[0], u ^ s[1]};
        return {1'b0, d[0]} + {1'b0, d[1]};
    endfunction

    // Add-compare-select for all four next states; ties keep the even predecessor.
    always_comb begin
        logic [1:0]      nb;
        logic [PM_W-1:0] c0, c1;
        nb     = '0;
        c0     = '0;
        c1     = '0;
        sv_acs = '0;
        for (int i = 0; i < 4; i++) pm_acs[i] = '0;
        for (int unsigned n = 0; n < 4; n++) begin
            nb = n[1:0];
            c0 = sat_add(pm_q[{nb[0], 1'b0}], bm(parities, {nb[0], 1'b0}, nb[1]));
            c1 = sat_add(pm_q[{nb[0], 1'b1}], bm(parities, {nb[0], 1'b1}, nb[1]));
            if (c1 < c0) begin
                pm_acs[nb] = c1;
                sv_acs[nb] = 1'b1;
            end else begin
                pm_acs[nb] = c0;
                sv_acs[nb] = 1'b0;
            end
        end
    end

    // Next-state and output decode for the ACS / TRACEBACK / OUTPUT phases.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tb_t_d    = tb_t_q;
        cur_d     = cur_q;
        idx_d     = idx_q;
        pm_d      = pm_q;
        metric_d  = metric_q;
        sv_d      = sv_q;
        buf_d     = buf_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_bit   = 1'b0;
        out_last  = 1'b0;
        case (state_q)
            ACS: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    pm_d        = pm_acs;
                    sv_d[cnt_q] = sv_acs;
                    if (cnt_q == CNT_W'(NSYM - 1)) begin
                        cnt_d    = '0;
                        metric_d = pm_acs[0];
                        tb_t_d   = CNT_W'(NSYM - 1);
                        cur_d    = '0;
                        state_d  = TRACEBACK;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            TRACEBACK: begin
                if (tb_t_q < CNT_W'(FRAME_LEN)) buf_d[tb_t_q[IDX_W-1:0]] = cur_q[1];
                cur_d = {cur_q[0], sv_q[tb_t_q][cur_q]};
                if (tb_t_q == '0) begin
                    idx_d   = '0;
                    state_d = OUTPUT;
                end else begin
                    tb_t_d = tb_t_q - 1'b1;
                end
            end
            OUTPUT: begin
                out_valid = 1'b1;
                out_bit   = buf_q[idx_q];
                out_last  = (idx_q == IDX_W'(FRAME_LEN - 1));
                if (out_ready) begin
                    if (out_last) begin
                        idx_d    = '0;
                        cnt_d    = '0;
                        pm_d[0]  = '0;
                        pm_d[1]  = PM_INIT;
                        pm_d[2]  = PM_INIT;
                        pm_d[3]  = PM_INIT;
                        state_d  = ACS;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = ACS;
        endcase
    end

    // Control and metric registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ACS;
            cnt_q    <= '0;
            tb_t_q   <= '0;
            cur_q    <= '0;
            idx_q    <= '0;
            pm_q[0]  <= '0;
            pm_q[1]  <= PM_INIT;
            pm_q[2]  <= PM_INIT;
            pm_q[3]  <= PM_INIT;
            metric_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            tb_t_q   <= tb_t_d;
            cur_q    <= cur_d;
            idx_q    <= idx_d;
            pm_q     <= pm_d;
            metric_q <= metric_d;
        end
    end

    // Survivor and output buffers are fully rewritten before each read, so no reset.
    always_ff @(posedge CLK) begin
        sv_q  <= sv_d;
        buf_q <= buf_d;
    end

    assign out_metric = metric_q;

endmodule
